control_pa5000: RTL and testbench

Sequencing control unit for the 5000 Hz high-pass IIR datapath. On each sample strobe it drives the datapath's register enables and mux selects through a fixed micro-sequence. The sequence computes the recursive state f(k) and the output y(k), then shifts the delay line. It signals completion with a one-cycle `done` pulse. It sits between the sample-rate tick generator and the datapath, one instance per filter channel.

---
 rtl/control_pa5000_pkg.sv | 72 +++++++
 rtl/control_pa5000_if.sv | 24 ++
 rtl/control_pa5000.sv | 42 ++++
 tb/tb_control_pa5000.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pa5000_pkg.sv
// rtl/control_pa5000_pkg.sv - state, mux and coefficient codes plus decode helpers for control_pa5000
package control_pa5000_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_F0    = 4'd1,
      ST_F1    = 4'd2,
      ST_F2    = 4'd3,
      ST_Y0    = 4'd4,
      ST_Y1    = 4'd5,
      ST_Y2    = 4'd6,
      ST_SHIFT = 4'd7,
      ST_DONE  = 4'd8
   } state_t;

   localparam logic [2:0] MS_UK  = 3'd0;
   localparam logic [2:0] MS_FK  = 3'd1;
   localparam logic [2:0] MS_FK1 = 3'd2;
   localparam logic [2:0] MS_FK2 = 3'd3;
   localparam logic [2:0] MS_YK  = 3'd4;

   localparam logic [1:0] K0 = 2'd0;
   localparam logic [1:0] K1 = 2'd1;
   localparam logic [1:0] K2 = 2'd2;
   localparam logic [1:0] K3 = 2'd3;

   localparam logic [1:0] MZ_ZERO = 2'd0;
   localparam logic [1:0] MZ_FK   = 2'd1;
   localparam logic [1:0] MZ_YK   = 2'd2;

   typedef struct packed {
      logic       en1;
      logic       en2;
      logic       en3;
      logic       en4;
      logic [2:0] mux_s;
      logic [1:0] mux_c;
      logic [1:0] mux_z;
      logic       ready;
      logic       done;
   } ctrl_t;

   function automatic state_t next_state(state_t s, logic start);
      case (s)
         ST_IDLE:  next_state = start ? ST_F0 : ST_IDLE;
         ST_F0, ST_F1, ST_F2, ST_Y0, ST_Y1, ST_Y2, ST_SHIFT:
                   next_state = state_t'(s + 4'd1);
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   endfunction

   // Per-state control word; anything not listed leaves every enable and select at 0.
   function automatic ctrl_t decode(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_IDLE:  c.ready = 1'b1;
         ST_F0:    begin c.en2 = 1'b1; c.mux_s = MS_UK;  c.mux_c = K0; c.mux_z = MZ_ZERO; end
         ST_F1:    begin c.en2 = 1'b1; c.mux_s = MS_FK1; c.mux_c = K2; c.mux_z = MZ_FK;   end
         ST_F2:    begin c.en2 = 1'b1; c.mux_s = MS_FK2; c.mux_c = K3; c.mux_z = MZ_FK;   end
         ST_Y0:    begin c.en1 = 1'b1; c.mux_s = MS_FK;  c.mux_c = K0; c.mux_z = MZ_ZERO; end
         ST_Y1:    begin c.en1 = 1'b1; c.mux_s = MS_FK1; c.mux_c = K1; c.mux_z = MZ_YK;   end
         ST_Y2:    begin c.en1 = 1'b1; c.mux_s = MS_FK2; c.mux_c = K0; c.mux_z = MZ_YK;   end
         ST_SHIFT: begin c.en3 = 1'b1; c.en4 = 1'b1; end
         ST_DONE:  c.done = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_pa5000_if.sv
// rtl/control_pa5000_if.sv - strobe and datapath control bundle between tick source, control_pa5000 and datapath
interface control_pa5000_if;
   logic       start;
   logic       en1;
   logic       en2;
   logic       en3;
   logic       en4;
   logic [2:0] muxS;
   logic [1:0] muxC;
   logic [1:0] muxZ;
   logic       ready;
   logic       done;
   logic       overrun;

   modport master (
      output start,
      input  en1, en2, en3, en4, muxS, muxC, muxZ, ready, done, overrun
   );

   modport slave (
      input  start,
      output en1, en2, en3, en4, muxS, muxC, muxZ, ready, done, overrun
   );
endinterface

// File: rtl/control_pa5000.sv
// rtl/control_pa5000.sv - micro-sequencer driving the 5000 Hz high-pass IIR datapath, one sample per strobe
module control_pa5000
   import control_pa5000_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_reset,
   control_pa5000_if.slave bus
);

   state_t r_state;
   ctrl_t  r_ctrl;
   logic   r_overrun;
   state_t w_next;

   assign w_next = next_state(r_state, bus.start);

   // Outputs are registered from the next state, so they always match the state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_ctrl    <= decode(ST_IDLE);
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ctrl  <= decode(w_next);
         if (bus.start && (r_state != ST_IDLE))
            r_overrun <= 1'b1;
      end
   end

   assign bus.en1     = r_ctrl.en1;
   assign bus.en2     = r_ctrl.en2;
   assign bus.en3     = r_ctrl.en3;
   assign bus.en4     = r_ctrl.en4;
   assign bus.muxS    = r_ctrl.mux_s;
   assign bus.muxC    = r_ctrl.mux_c;
   assign bus.muxZ    = r_ctrl.mux_z;
   assign bus.ready   = r_ctrl.ready;
   assign bus.done    = r_ctrl.done;
   assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_control_pa5000.sv
// tb/tb_control_pa5000.sv - directed bench for control_pa5000 with a behavioural datapath
module tb_control_pa5000;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   cyc;

   control_pa5000_if bus ();

   control_pa5000 dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // {en1,en2,en3,en4,muxS,muxC,muxZ,ready,done}; rows F0..DONE then IDLE
   logic [12:0] exp_seq [0:8];
   logic [12:0] obs;
   assign obs = {bus.en1, bus.en2, bus.en3, bus.en4, bus.muxS, bus.muxC, bus.muxZ, bus.ready, bus.done};

   // Datapath model: resul = dato1*dato2 + dato3 with K0=1, K1=-2, K2=K3=0
   logic signed [15:0] uk, fk, fk1, fk2, yk;
   logic signed [15:0] d1, d2, d3, resul;
   always_comb begin
      d1 = '0;
      d2 = '0;
      d3 = '0;
      case (bus.muxS)
         3'd0: d1 = uk;
         3'd1: d1 = fk;
         3'd2: d1 = fk1;
         3'd3: d1 = fk2;
         3'd4: d1 = yk;
         default: d1 = '0;
      endcase
      case (bus.muxC)
         2'd0: d2 = 16'sd1;
         2'd1: d2 = -16'sd2;
         default: d2 = 16'sd0;
      endcase
      case (bus.muxZ)
         2'd1: d3 = fk;
         2'd2: d3 = yk;
         default: d3 = '0;
      endcase
      resul = d1 * d2 + d3;
   end

   always @(posedge clk) begin
      if (reset) begin
         fk <= '0; fk1 <= '0; fk2 <= '0; yk <= '0;
      end else begin
         if (bus.en2) fk  <= resul;
         if (bus.en1) yk  <= resul;
         if (bus.en3) fk1 <= fk;
         if (bus.en4) fk2 <= fk1;
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      tick(n);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(2);
      for (int i = 0; i < 20; i++) begin
         total++;
         if (obs !== exp_seq[8] || bus.overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle c%0d: got %b ovr=%b want %b ovr=0", i, obs, bus.overrun, exp_seq[8]);
         end
         tick(1);
      end
   endtask

   task automatic test_single();
      do_reset(2);
      tick(3);
      pulse_start();
      for (int s = 0; s < 9; s++) begin
         total++;
         if (obs !== exp_seq[s]) begin
            bad++;
            $display("FAIL single_step%0d: got %b want %b", s, obs, exp_seq[s]);
         end
         if (s < 8) tick(1);
      end
      total++;
      if (bus.overrun !== 1'b0) begin
         bad++;
         $display("FAIL single_overrun: got %b want 0", bus.overrun);
      end
   endtask

   task automatic test_datapath();
      logic signed [15:0] ey [0:3];
      logic signed [15:0] ef1 [0:3];
      logic signed [15:0] ef2 [0:3];
      ey[0] = 16'sd1;  ey[1] = -16'sd2; ey[2] = 16'sd1;  ey[3] = 16'sd0;
      ef1[0] = 16'sd1; ef1[1] = 16'sd0; ef1[2] = 16'sd0; ef1[3] = 16'sd0;
      ef2[0] = 16'sd0; ef2[1] = 16'sd1; ef2[2] = 16'sd0; ef2[3] = 16'sd0;
      do_reset(2);
      for (int k = 0; k < 4; k++) begin
         uk = (k == 0) ? 16'sd1 : 16'sd0;
         pulse_start();
         tick(7);
         total++;
         if (bus.done !== 1'b1 || yk !== ey[k]) begin
            bad++;
            $display("FAIL dp_yk%0d: got yk=%0d done=%b want yk=%0d done=1", k, yk, bus.done, ey[k]);
         end
         total++;
         if (fk1 !== ef1[k] || fk2 !== ef2[k]) begin
            bad++;
            $display("FAIL dp_shift%0d: got fk1=%0d fk2=%0d want fk1=%0d fk2=%0d", k, fk1, fk2, ef1[k], ef2[k]);
         end
         tick(1);
      end
   endtask

   task automatic test_overrun();
      do_reset(2);
      pulse_start();
      tick(3);
      pulse_start();
      total++;
      if (bus.overrun !== 1'b1 || obs !== exp_seq[4]) begin
         bad++;
         $display("FAIL overrun_set: got ovr=%b %b want ovr=1 %b", bus.overrun, obs, exp_seq[4]);
      end
      tick(3);
      total++;
      if (obs !== exp_seq[7]) begin
         bad++;
         $display("FAIL overrun_done: got %b want %b", obs, exp_seq[7]);
      end
      tick(1);
      total++;
      if (obs !== exp_seq[8] || bus.overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_sticky: got %b ovr=%b want %b ovr=1", obs, bus.overrun, exp_seq[8]);
      end
      do_reset(1);
      total++;
      if (bus.overrun !== 1'b0) begin
         bad++;
         $display("FAIL overrun_clear: got %b want 0", bus.overrun);
      end
   endtask

   task automatic test_back_to_back();
      int last_done;
      do_reset(2);
      last_done = 0;
      for (int i = 0; i < 5; i++) begin
         pulse_start();
         total++;
         if (obs !== exp_seq[0]) begin
            bad++;
            $display("FAIL b2b_accept%0d: got %b want %b", i, obs, exp_seq[0]);
         end
         tick(7);
         total++;
         if (bus.done !== 1'b1 || (i > 0 && (cyc - last_done) != 9)) begin
            bad++;
            $display("FAIL b2b_done%0d: got done=%b gap=%0d want done=1 gap=9", i, bus.done, cyc - last_done);
         end
         last_done = cyc;
         tick(1);
      end
      total++;
      if (bus.overrun !== 1'b0) begin
         bad++;
         $display("FAIL b2b_overrun: got %b want 0", bus.overrun);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(2);
      pulse_start();
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs !== exp_seq[8]) begin
            bad++;
            $display("FAIL reset_mid c%0d: got %b want %b", i, obs, exp_seq[8]);
         end
         tick(1);
      end
      reset = 1'b1;
      bus.start = 1'b1;
      tick(1);
      reset = 1'b0;
      bus.start = 1'b0;
      tick(1);
      total++;
      if (obs !== exp_seq[8] || bus.overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_with_start: got %b ovr=%b want %b ovr=0", obs, bus.overrun, exp_seq[8]);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      cyc = 0;
      reset = 1'b1;
      bus.start = 1'b0;
      uk = '0;
      exp_seq[0] = 13'b0100_000_00_00_0_0;
      exp_seq[1] = 13'b0100_010_10_01_0_0;
      exp_seq[2] = 13'b0100_011_11_01_0_0;
      exp_seq[3] = 13'b1000_001_00_00_0_0;
      exp_seq[4] = 13'b1000_010_01_10_0_0;
      exp_seq[5] = 13'b1000_011_00_10_0_0;
      exp_seq[6] = 13'b0011_000_00_00_0_0;
      exp_seq[7] = 13'b0000_000_00_00_0_1;
      exp_seq[8] = 13'b0000_000_00_00_1_0;
      test_reset();
      test_single();
      test_datapath();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
